// File: rtl/fetch_if_id_pkg.sv
// Shared types and constants for the fetch stage and IF/ID register.
// Opcode field is instr[15:11]; HALT is the all-zero opcode.
package fetch_if_id_pkg;

    typedef logic [15:0] word_t;
    typedef logic [15:0] addr_t;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;

    localparam word_t NOP_INSTR = {OP_NOP, 11'd0};

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_e;

    function automatic logic is_halt(word_t w);
        return w[15:11] == OP_HALT;
    endfunction

    function automatic addr_t pc_inc(addr_t a);
        return a + 16'd2;
    endfunction

endpackage

// File: rtl/fetch_if_id_if.sv
// Instruction-memory request/response and IF/ID output bundle.
// master = fetch stage, slave = memory / decode environment.
interface fetch_if_id_if;
    import fetch_if_id_pkg::*;

    logic  imem_req;
    addr_t imem_addr;
    logic  imem_valid;
    word_t imem_rdata;

    logic  stall;
    logic  redirect;
    addr_t redirect_pc;

    word_t id_instr;
    addr_t id_pc_inc;
    logic  id_valid;
    logic  is_rst;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata,
        input  stall,
        input  redirect,
        input  redirect_pc,
        output id_instr,
        output id_pc_inc,
        output id_valid,
        output is_rst
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata,
        output stall,
        output redirect,
        output redirect_pc,
        input  id_instr,
        input  id_pc_inc,
        input  id_valid,
        input  is_rst
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a response IF/ID could not accept.
// Priority: clear, then load, then drain.
module fetch_skid_buf
    import fetch_if_id_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load_i,
    input  logic  clear_i,
    input  logic  drain_i,
    input  word_t instr_i,
    input  addr_t pc_i,
    output logic  valid_o,
    output word_t instr_o,
    output addr_t pc_o
);

    logic  valid_q;
    word_t instr_q;
    addr_t pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_if_id.sv
// Instruction fetch with one outstanding request, skid buffer,
// EX redirect / ID stall handling, HALT stop and IF/ID register.
module fetch_if_id
    import fetch_if_id_pkg::*;
#(
    parameter addr_t RESET_PC  = 16'h0000,
    parameter word_t NOP_INSTR = fetch_if_id_pkg::NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_if_id_if.master bus
);

    fetch_state_e state_q, state_d;
    addr_t fetch_pc_q, fetch_pc_d;
    addr_t resp_pc_q, resp_pc_d;
    logic  squash_q, squash_d;

    word_t id_instr_q, id_instr_d;
    addr_t id_pc_inc_q, id_pc_inc_d;
    logic  id_valid_q, id_valid_d;
    logic  is_rst_q, is_rst_d;

    logic  buf_valid;
    word_t buf_instr;
    addr_t buf_pc;

    logic accept;
    logic resp;
    logic live;
    logic rsp_halt;
    logic issue;
    logic buf_load;
    logic buf_drain;

    always_comb begin
        accept    = !bus.stall || !id_valid_q;
        resp      = (state_q == S_WAIT) && bus.imem_valid;
        live      = resp && !squash_q && !bus.redirect;
        rsp_halt  = is_halt(bus.imem_rdata);
        issue     = !bus.redirect && !buf_valid &&
                    ((state_q == S_FETCH) ||
                     (live && accept && !rsp_halt));
        buf_load  = live && !accept;
        buf_drain = accept && buf_valid;
    end

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (buf_load),
        .clear_i (bus.redirect),
        .drain_i (buf_drain),
        .instr_i (bus.imem_rdata),
        .pc_i    (resp_pc_q),
        .valid_o (buf_valid),
        .instr_o (buf_instr),
        .pc_o    (buf_pc)
    );

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        resp_pc_d   = resp_pc_q;
        squash_d    = squash_q;
        id_instr_d  = id_instr_q;
        id_pc_inc_d = id_pc_inc_q;
        id_valid_d  = id_valid_q;
        is_rst_d    = is_rst_q;

        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
            // An in-flight request must still drain; mark it dead.
            if (state_q == S_WAIT && !bus.imem_valid) begin
                squash_d = 1'b1;
                state_d  = S_WAIT;
            end else begin
                squash_d = 1'b0;
                state_d  = S_FETCH;
            end
        end else begin
            if (resp) begin
                squash_d = 1'b0;
                state_d  = (!squash_q && rsp_halt) ? S_HALT : S_FETCH;
            end

            if (issue) begin
                resp_pc_d  = fetch_pc_q;
                fetch_pc_d = pc_inc(fetch_pc_q);
                state_d    = S_WAIT;
            end

            if (accept) begin
                if (buf_valid) begin
                    id_instr_d  = buf_instr;
                    id_pc_inc_d = pc_inc(buf_pc);
                    id_valid_d  = 1'b1;
                    is_rst_d    = 1'b0;
                end else if (live) begin
                    id_instr_d  = bus.imem_rdata;
                    id_pc_inc_d = pc_inc(resp_pc_q);
                    id_valid_d  = 1'b1;
                    is_rst_d    = 1'b0;
                end else begin
                    // ID consumed its slot and nothing is ready: bubble.
                    id_instr_d = NOP_INSTR;
                    id_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            fetch_pc_q  <= RESET_PC;
            resp_pc_q   <= RESET_PC;
            squash_q    <= 1'b0;
            id_instr_q  <= NOP_INSTR;
            id_pc_inc_q <= '0;
            id_valid_q  <= 1'b0;
            is_rst_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            resp_pc_q   <= resp_pc_d;
            squash_q    <= squash_d;
            id_instr_q  <= id_instr_d;
            id_pc_inc_q <= id_pc_inc_d;
            id_valid_q  <= id_valid_d;
            is_rst_q    <= is_rst_d;
        end
    end

    assign bus.imem_req  = rst_n && issue;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.id_instr  = id_instr_q;
    assign bus.id_pc_inc = id_pc_inc_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.is_rst    = is_rst_q;

endmodule

// File: tb/tb_fetch_if_id.sv
// Bench for fetch_if_id: directed scenarios plus random traffic
// checked against a program-order model of what ID executes.
module tb_fetch_if_id;
    import fetch_if_id_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fetch_if_id_if bus();

    fetch_if_id #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0800)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic  rst_n_n = 1'b0;
    logic  stall_n = 1'b0;
    logic  redir_n = 1'b0;
    logic  stale_n = 1'b0;
    addr_t rpc_n = '0;
    int    lat_n = 1;

    addr_t halt_addr = 16'h0001;
    logic  rand_halt = 1'b0;

    logic  pend = 1'b0;
    addr_t pend_addr = '0;
    int    due = 0;

    addr_t exp_pc = '0;
    logic  halted = 1'b0;
    int    consumed = 0;

    function automatic word_t mem_at(addr_t a);
        if (a == halt_addr) return 16'h0000;
        if (rand_halt && a[6:1] == 6'h2A) return 16'h0000;
        return 16'h4000 | (((a << 4) + (a >> 1)) & 16'h07FF);
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cyc %0d): got %0h want %0h",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic cycle();
        word_t w;
        logic  rsp;
        @(posedge clk);
        #1;
        cyc++;
        rst_n           = rst_n_n;
        bus.stall       = stall_n;
        bus.redirect    = redir_n;
        bus.redirect_pc = rpc_n;
        rsp             = pend && (cyc == due);
        bus.imem_valid  = stale_n || rsp;
        bus.imem_rdata  = stale_n ? 16'h5555 :
                          rsp ? mem_at(pend_addr) : 16'hDEAD;
        @(negedge clk);
        if (!rst_n) begin
            pend   = 1'b0;
            exp_pc = 16'h0000;
            halted = 1'b0;
        end else begin
            if (rsp) pend = 1'b0;
            if (bus.imem_req) begin
                check("one_outstanding", pend, 0);
                pend      = 1'b1;
                pend_addr = bus.imem_addr;
                due       = cyc + lat_n;
            end
            if (halted) check("halt_no_req", bus.imem_req, 0);
            if (bus.id_valid && !bus.stall && !bus.redirect) begin
                w = mem_at(exp_pc);
                check("exec_after_halt", halted, 0);
                check("order_pc", bus.id_pc_inc, addr_t'(exp_pc + 16'd2));
                check("order_instr", bus.id_instr, w);
                if (w[15:11] == OP_HALT) halted = 1'b1;
                exp_pc = exp_pc + 16'd2;
                consumed++;
            end
            if (bus.redirect) begin
                exp_pc = bus.redirect_pc;
                halted = 1'b0;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst_n_n = 1'b0;
        stall_n = 1'b0;
        redir_n = 1'b0;
        stale_n = 1'b0;
        lat_n   = 1;
        run(2);
        rst_n_n = 1'b1;
    endtask

    initial begin
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_valid  = 1'b0;
        bus.imem_rdata  = '0;
        #2 rst_n = 1'b0;

        // reset values, then 1-cycle memory streaming
        do_reset();
        check("rst_req", bus.imem_req, 0);
        check("rst_instr", bus.id_instr, 16'h0800);
        check("rst_pcinc", bus.id_pc_inc, 0);
        check("rst_valid", bus.id_valid, 0);
        check("rst_isrst", bus.is_rst, 1);
        cycle();
        check("c0_req", bus.imem_req, 1);
        check("c0_addr", bus.imem_addr, 16'h0000);
        cycle();
        check("c1_addr", bus.imem_addr, 16'h0002);
        check("c1_isrst", bus.is_rst, 1);
        check("c1_valid", bus.id_valid, 0);
        cycle();
        check("c2_addr", bus.imem_addr, 16'h0004);
        check("c2_instr", bus.id_instr, 16'h4000);
        check("c2_pcinc", bus.id_pc_inc, 16'h0002);
        check("c2_isrst", bus.is_rst, 0);
        check("c2_valid", bus.id_valid, 1);
        cycle();
        check("c3_instr", bus.id_instr, 16'h4021);
        check("c3_pcinc", bus.id_pc_inc, 16'h0004);
        check("c3_valid", bus.id_valid, 1);
        cycle();
        check("c4_instr", bus.id_instr, 16'h4042);
        check("c4_pcinc", bus.id_pc_inc, 16'h0006);
        check("c4_valid", bus.id_valid, 1);

        // stall while the addr-4 response arrives
        do_reset();
        run(3);
        stall_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stl_hold_pc", bus.id_pc_inc, 16'h0004);
            check("stl_hold_in", bus.id_instr, 16'h4021);
            check("stl_no_req", bus.imem_req, 0);
        end
        stall_n = 1'b0;
        cycle();
        check("stl_drain_req", bus.imem_req, 0);
        cycle();
        check("stl_buf_pc", bus.id_pc_inc, 16'h0006);
        check("stl_buf_in", bus.id_instr, 16'h4042);
        check("stl_next_req", bus.imem_req, 1);
        check("stl_next_addr", bus.imem_addr, 16'h0006);

        // redirect while a 3-cycle request is outstanding
        do_reset();
        run(4);
        lat_n = 3;
        cycle();
        check("rd_req8", bus.imem_addr, 16'h0008);
        redir_n = 1'b1;
        rpc_n   = 16'h0100;
        cycle();
        redir_n = 1'b0;
        cycle();
        check("rd_bub_in", bus.id_instr, 16'h0800);
        check("rd_bub_v", bus.id_valid, 0);
        check("rd_wait_req", bus.imem_req, 0);
        cycle();
        check("rd_drop_req", bus.imem_req, 0);
        check("rd_drop_v", bus.id_valid, 0);
        lat_n = 1;
        cycle();
        check("rd_new_req", bus.imem_req, 1);
        check("rd_new_addr", bus.imem_addr, 16'h0100);
        run(2);
        check("rd_tgt_pc", bus.id_pc_inc, 16'h0102);
        check("rd_tgt_in", bus.id_instr, 16'h4080);

        // HALT at 0x0010, then resume by redirect
        halt_addr = 16'h0010;
        do_reset();
        run(9);
        check("h_req_addr", bus.imem_addr, 16'h0010);
        cycle();
        check("h_resp_req", bus.imem_req, 0);
        cycle();
        check("h_instr", bus.id_instr, 16'h0000);
        check("h_pcinc", bus.id_pc_inc, 16'h0012);
        check("h_valid", bus.id_valid, 1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("h_quiet", bus.imem_req, 0);
        end
        redir_n = 1'b1;
        rpc_n   = 16'h0020;
        cycle();
        redir_n = 1'b0;
        cycle();
        check("h_res_req", bus.imem_req, 1);
        check("h_res_addr", bus.imem_addr, 16'h0020);
        halt_addr = 16'h0001;

        // redirect and stall together with a full buffer
        do_reset();
        run(3);
        stall_n = 1'b1;
        run(2);
        redir_n = 1'b1;
        rpc_n   = 16'h0040;
        cycle();
        stall_n = 1'b0;
        redir_n = 1'b0;
        cycle();
        check("rs_bub_v", bus.id_valid, 0);
        check("rs_bub_in", bus.id_instr, 16'h0800);
        check("rs_req", bus.imem_req, 1);
        check("rs_addr", bus.imem_addr, 16'h0040);
        run(2);
        check("rs_pcinc", bus.id_pc_inc, 16'h0042);
        check("rs_instr", bus.id_instr, 16'h4420);
        check("rs_valid", bus.id_valid, 1);

        // address wrap at 0xFFFE
        do_reset();
        redir_n = 1'b1;
        rpc_n   = 16'hFFFE;
        cycle();
        check("w_redir_req", bus.imem_req, 0);
        redir_n = 1'b0;
        cycle();
        check("w_req", bus.imem_req, 1);
        check("w_addr", bus.imem_addr, 16'hFFFE);
        cycle();
        check("w_wrap_req", bus.imem_req, 1);
        check("w_wrap_addr", bus.imem_addr, 16'h0000);
        cycle();
        check("w_pcinc", bus.id_pc_inc, 16'h0000);
        check("w_instr", bus.id_instr, 16'h47DF);

        // reset mid-request, stale response on release
        do_reset();
        run(2);
        lat_n = 3;
        cycle();
        check("mr_pre_v", bus.id_valid, 1);
        rst_n_n = 1'b0;
        cycle();
        check("mr_req", bus.imem_req, 0);
        check("mr_valid", bus.id_valid, 0);
        check("mr_instr", bus.id_instr, 16'h0800);
        check("mr_pcinc", bus.id_pc_inc, 0);
        check("mr_isrst", bus.is_rst, 1);
        rst_n_n = 1'b1;
        stale_n = 1'b1;
        lat_n   = 1;
        cycle();
        check("mr_rel_req", bus.imem_req, 1);
        check("mr_rel_addr", bus.imem_addr, 16'h0000);
        stale_n = 1'b0;
        cycle();
        check("mr_stale_v", bus.id_valid, 0);
        check("mr_stale_rst", bus.is_rst, 1);
        cycle();
        check("mr_ok_pc", bus.id_pc_inc, 16'h0002);
        check("mr_ok_in", bus.id_instr, 16'h4000);
        check("mr_ok_rst", bus.is_rst, 0);

        // random traffic against the program-order model
        rand_halt = 1'b1;
        do_reset();
        consumed = 0;
        for (int i = 0; i < 4000; i++) begin
            stall_n = ($urandom_range(0, 99) < 30);
            redir_n = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 9) == 0)
                rpc_n = 16'hFFF0 + (addr_t'($urandom_range(0, 7)) << 1);
            else
                rpc_n = addr_t'($urandom_range(0, 127)) << 1;
            lat_n = $urandom_range(1, 3);
            cycle();
        end
        check("rand_progress", (consumed > 200), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_if_id.md
# fetch_if_id

Instruction-fetch stage and IF/ID pipeline register of the 16-bit pipelined core. It issues instruction-memory/cache requests and absorbs variable response latency with a one-entry skid buffer. It applies ID-stage stalls and EX-stage redirects, and stops fetching after a HALT. Its outputs feed the decode control block directly, including the `is_rst` qualifier that suppresses a false HALT decode out of reset.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, first fetch address after reset
- `NOP_INSTR`, 16'h0800, bubble instruction driven into IF/ID (opcode 00001)

Ports:
- `clk` in 1, single clock
- `rst_n` in 1, asynchronous active-low reset
- `imem_req` out 1, one-cycle request strobe; forced 0 while `rst_n`=0
- `imem_addr` out 16, request address (= `fetch_pc`)
- `imem_valid` in 1, response strobe, ≥1 cycle after `imem_req`; at most one outstanding
- `imem_rdata` in 16, instruction, valid with `imem_valid`
- `stall` in 1, ID hazard: IF/ID must hold
- `redirect` in 1, taken branch/jump resolved in EX
- `redirect_pc` in 16, target address
- `id_instr` out 16, IF/ID instruction; reset `NOP_INSTR`
- `id_pc_inc` out 16, address of `id_instr` + 2; reset 0
- `id_valid` out 1, IF/ID holds a real instruction; reset 0
- `is_rst` out 1, high from reset until first real instruction enters IF/ID; reset 1

## Operation
- Registers: `state`, `fetch_pc` (next address to request), `resp_pc` (address of outstanding request), `squash`, `buf_valid`/`buf_instr`/`buf_pc`, IF/ID.
- States:
  - S_FETCH: reset state; may issue.
  - S_WAIT: one request outstanding.
  - S_HALT: HALT fetched; no requests.
- Issue (`imem_req`=1) when `redirect`=0, `buf_valid`=0, and either:
  - state=S_FETCH; or
  - state=S_WAIT, `imem_valid`=1, response accepted into IF/ID this cycle, not squashed, not HALT (back-to-back).
- On issue: `resp_pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+2 (mod 2^16, FFFE wraps to 0000), state<=S_WAIT.
- IF/ID accepts when `stall`=0 or `id_valid`=0.
  - Load source: the buffer if `buf_valid`, else the live unsquashed response.
  - A live response arriving while IF/ID cannot accept goes to the buffer.
  - `id_pc_inc` = source pc + 2.
  - The first load clears `is_rst`.
- Response handling in S_WAIT with `imem_valid`:
  - If `squash`: drop the response, clear `squash`, go to S_FETCH.
  - Else, if `imem_rdata[15:11]`=00000 (HALT): deliver/buffer it, go to S_HALT.
  - Otherwise: go to S_FETCH, unless a back-to-back issue occurs (stay S_WAIT).
- `redirect` has priority over everything, including `stall`:
  - `fetch_pc`<=`redirect_pc`.
  - IF/ID<=`NOP_INSTR`, `id_valid`<=0.
  - `buf_valid`<=0.
  - In S_WAIT without `imem_valid`: `squash`<=1, stay S_WAIT.
  - In S_WAIT with `imem_valid`: response dropped, go to S_FETCH.
  - S_HALT or S_FETCH: go to S_FETCH.
- `stall`=1 with `id_valid`=0 does not block loading.
- `is_rst` never re-asserts except on reset.

## Timing
- Reset asserted mid-request: all state cleared immediately; a late `imem_valid` after release is ignored, since state=S_FETCH is not S_WAIT.
- Cycle 0 = first edge after `rst_n` rises: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Response in cycle N appears on `id_instr`/`id_valid` in cycle N+1.
- With 1-cycle memory and no stalls: one instruction per cycle.
- Redirect in cycle N: bubble in IF/ID in N+1; new request in N+1 if not waiting, else the cycle after the squashed response.

## Structure
- Shared package holds:
  - `OP_HALT`=5'b00000, `OP_NOP`=5'b00001, `NOP_INSTR`.
  - State encoding (S_FETCH, S_WAIT, S_HALT).
  - 16-bit word/address typedefs.
- Skid buffer is a natural sub-module, `fetch_skid_buf`: valid/instr/pc, load/clear/drain.

## Test plan
- Reset release, 1-cycle memory returning 0x4000, 0x4021, 0x4042: `imem_addr` 0, 2, 4 in consecutive cycles; `id_pc_inc` 2, 4, 6; `is_rst` falls with first load; `id_valid` stays 1.
- `stall`=1 for 3 cycles while a response for addr 4 arrives: IF/ID holds the addr-2 instruction; response is buffered and no new `imem_req` issues; on release the buffered instruction loads with `id_pc_inc`=6, then a request for addr 6.
- `redirect` to 0x0100 while a 3-cycle request for addr 8 is outstanding: IF/ID becomes 0x0800/`id_valid`=0; the addr-8 response is dropped; next `imem_addr`=0x0100.
- HALT (0x0000) returned at addr 0x0010: loaded with `id_pc_inc`=0x0012, no further `imem_req`; later `redirect` to 0x0020 resumes fetching at 0x0020.
- `redirect` and `stall` in the same cycle: redirect wins, bubble inserted, buffer cleared.
- `fetch_pc`=0xFFFE: request issues at 0xFFFE, next request at 0x0000; `id_pc_inc`=0x0000.
- `rst_n` low mid-request: all outputs return to reset values immediately; a stale `imem_valid` after release is not loaded into IF/ID.
